// File: rtl/mvm_pkg.sv
// -----------------------------------------------------------------------------
// mvm_pkg
// Shared types and constants for the matrix-vector multiply controller and
// its datapath.
//   mvm_state_e   : controller FSM state encoding
//   DEF_MAT_SCALE : default matrix dimension M
//   INPUT_WIDTH   : default signed width of A/x elements on the data stream
//   OUTPUT_WIDTH  : default width of a y element (full product + growth)
//   RD_LAT        : read-address-to-data latency of the A and x memories
//   WB_LAT        : cycles from the last read of a row to its y writeback
//   cnt_width()   : counter width helper that never returns zero
// -----------------------------------------------------------------------------
package mvm_pkg;

    localparam int DEF_MAT_SCALE = 4;
    localparam int INPUT_WIDTH   = 8;
    localparam int OUTPUT_WIDTH  = 2 * INPUT_WIDTH + $clog2(DEF_MAT_SCALE);

    localparam int RD_LAT = 1;
    localparam int WB_LAT = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_X = 3'd2,
        ST_CALC   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5,
        ST_OUT    = 3'd6
    } mvm_state_e;

    // A dimension of 1 still needs a 1-bit register so the port exists.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_idx_cnt.sv
// -----------------------------------------------------------------------------
// mvm_idx_cnt
// Two-level (row, col) wrapping index counter. col is the inner index; row
// advances when col wraps, and both return to 0 after the last element.
// The counter only moves while en is high, so it rests at 0 between uses.
//   clk      : rising-edge clock
//   reset    : asynchronous, active-low reset
//   en       : advance one position this cycle
//   row      : outer index, 0..ROWS-1
//   col      : inner index, 0..COLS-1
//   col_last : col is at COLS-1
//   last     : row and col are both at their final value
// -----------------------------------------------------------------------------
module mvm_idx_cnt
    import mvm_pkg::*;
#(
    parameter  int ROWS = 4,
    parameter  int COLS = 4,
    localparam int RW   = cnt_width(ROWS),
    localparam int CW   = cnt_width(COLS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          col_last,
    output logic          last
);

    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

    assign col_last = (col == COL_MAX);
    assign last     = col_last && (row == ROW_MAX);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_last) begin
                col <= '0;
                row <= (row == ROW_MAX) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mvm_ctrl.sv
// -----------------------------------------------------------------------------
// mvm_ctrl
// Control FSM and address sequencer for an M x M signed matrix-vector
// multiply y = A*x. It loads A (row-major) and x from a serial stream,
// issues pipelined reads with MAC and writeback control, pulses done, then
// steps the y output mux. No arithmetic on data lives here.
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   start      : begin a job; only looked at in IDLE
//   busy       : any state other than IDLE
//   wr_en_a    : A memory write enable      wr_addr_a : A write address j*M+k
//   wr_en_x    : x memory write enable      wr_addr_x : x write address
//   rd_addr_a  : A read address             rd_addr_x : x read address
//   en_acc     : MAC enable, one cycle after each read issue
//   clear_acc  : with en_acc, load the product instead of accumulating
//   y_we       : capture the accumulator into y row y_addr
//   done       : one-cycle completion pulse
//   out_valid  : data_out valid; out_row selects the y row shown
//
// Handshake: start is a level sampled on each rising edge while IDLE; a
// sample of 1 launches exactly one job and the level is ignored in every
// other state, so holding it high runs jobs back to back with one IDLE cycle
// between them.
// -----------------------------------------------------------------------------
module mvm_ctrl
    import mvm_pkg::*;
#(
    parameter  int MAT_SCALE = DEF_MAT_SCALE,
    localparam int AW_A      = $clog2(MAT_SCALE * MAT_SCALE),
    localparam int AW_X      = $clog2(MAT_SCALE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            wr_en_a,
    output logic [AW_A-1:0] wr_addr_a,
    output logic            wr_en_x,
    output logic [AW_X-1:0] wr_addr_x,
    output logic [AW_A-1:0] rd_addr_a,
    output logic [AW_X-1:0] rd_addr_x,
    output logic            en_acc,
    output logic            clear_acc,
    output logic            y_we,
    output logic [AW_X-1:0] y_addr,
    output logic            done,
    output logic            out_valid,
    output logic [AW_X-1:0] out_row
);

    mvm_state_e state;
    mvm_state_e state_next;

    // Counter enables, decoded from state in the output process.
    logic a_en;
    logic s_en;
    logic c_en;

    // A load indexing (row-major over M x M).
    logic [AW_X-1:0] a_row;
    logic [AW_X-1:0] a_col;
    logic            a_col_last;
    logic            a_last;

    // Single-dimension sequencer shared by LOAD_X and OUT; the two states
    // never overlap and the counter is back at 0 when LOAD_X ends.
    logic            s_row;
    logic [AW_X-1:0] s_col;
    logic            s_col_last;
    logic            s_last;

    // CALC indexing: c_row is j (outer), c_col is k (inner).
    logic [AW_X-1:0] c_row;
    logic [AW_X-1:0] c_col;
    logic            c_col_last;
    logic            c_last;

    mvm_idx_cnt #(
        .ROWS (MAT_SCALE),
        .COLS (MAT_SCALE)
    ) u_cnt_load (
        .clk      (clk),
        .reset    (reset),
        .en       (a_en),
        .row      (a_row),
        .col      (a_col),
        .col_last (a_col_last),
        .last     (a_last)
    );

    mvm_idx_cnt #(
        .ROWS (1),
        .COLS (MAT_SCALE)
    ) u_cnt_seq (
        .clk      (clk),
        .reset    (reset),
        .en       (s_en),
        .row      (s_row),
        .col      (s_col),
        .col_last (s_col_last),
        .last     (s_last)
    );

    mvm_idx_cnt #(
        .ROWS (MAT_SCALE),
        .COLS (MAT_SCALE)
    ) u_cnt_calc (
        .clk      (clk),
        .reset    (reset),
        .en       (c_en),
        .row      (c_row),
        .col      (c_col),
        .col_last (c_col_last),
        .last     (c_last)
    );

    // Counter flags that this controller has no use for.
    logic unused_cnt_flags;
    assign unused_cnt_flags = &{1'b0, a_col_last, s_row, s_col_last};

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state. Every multi-cycle state leaves only on its counter's
    // final position, so state lengths follow directly from MAT_SCALE.
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start)  state_next = ST_LOAD_A;
            ST_LOAD_A: if (a_last) state_next = ST_LOAD_X;
            ST_LOAD_X: if (s_last) state_next = ST_CALC;
            ST_CALC:   if (c_last) state_next = ST_DRAIN;
            ST_DRAIN:              state_next = ST_DONE;
            ST_DONE:               state_next = ST_OUT;
            ST_OUT:    if (s_last) state_next = ST_IDLE;
            default:               state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: state-decoded outputs and counter enables. Addresses are forced to
    // 0 outside the state that owns them.
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = 1'b0;
        wr_en_a   = 1'b0;
        wr_addr_a = '0;
        wr_en_x   = 1'b0;
        wr_addr_x = '0;
        rd_addr_a = '0;
        rd_addr_x = '0;
        done      = 1'b0;
        out_valid = 1'b0;
        out_row   = '0;
        a_en      = 1'b0;
        s_en      = 1'b0;
        c_en      = 1'b0;
        case (state)
            ST_LOAD_A: begin
                busy      = 1'b1;
                a_en      = 1'b1;
                wr_en_a   = 1'b1;
                wr_addr_a = AW_A'(a_row) * AW_A'(MAT_SCALE) + AW_A'(a_col);
            end
            ST_LOAD_X: begin
                busy      = 1'b1;
                s_en      = 1'b1;
                wr_en_x   = 1'b1;
                wr_addr_x = s_col;
            end
            ST_CALC: begin
                busy      = 1'b1;
                c_en      = 1'b1;
                rd_addr_a = AW_A'(c_row) * AW_A'(MAT_SCALE) + AW_A'(c_col);
                rd_addr_x = c_col;
            end
            ST_DRAIN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            ST_OUT: begin
                busy      = 1'b1;
                s_en      = 1'b1;
                out_valid = 1'b1;
                out_row   = s_col;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // MAC / writeback pipeline. Each CALC read issue launches a token that
    // reaches en_acc after the memory read latency. The last read of a row
    // launches a writeback token that reaches y_we after WB_LAT cycles: one
    // for the read, one for the final accumulate. The row index rides along
    // and is zero whenever no writeback is in flight.
    // -------------------------------------------------------------------------
    logic                 issue_acc;
    logic                 issue_clr;
    logic                 issue_wb;
    logic [RD_LAT-1:0]    acc_pipe;
    logic [RD_LAT-1:0]    clr_pipe;
    logic [WB_LAT-1:0]    wb_pipe;
    logic [AW_X-1:0]      row_pipe [WB_LAT];

    assign issue_acc = c_en;
    assign issue_clr = c_en && (c_col == '0);
    assign issue_wb  = c_en && c_col_last;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_pipe <= '0;
            clr_pipe <= '0;
            wb_pipe  <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                row_pipe[i] <= '0;
            end
        end else begin
            acc_pipe[0] <= issue_acc;
            clr_pipe[0] <= issue_clr;
            wb_pipe[0]  <= issue_wb;
            row_pipe[0] <= issue_wb ? c_row : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                acc_pipe[i] <= acc_pipe[i-1];
                clr_pipe[i] <= clr_pipe[i-1];
            end
            for (int i = 1; i < WB_LAT; i++) begin
                wb_pipe[i]  <= wb_pipe[i-1];
                row_pipe[i] <= row_pipe[i-1];
            end
        end
    end

    assign en_acc    = acc_pipe[RD_LAT-1];
    assign clear_acc = clr_pipe[RD_LAT-1];
    assign y_we      = wb_pipe[WB_LAT-1];
    assign y_addr    = row_pipe[WB_LAT-1];

endmodule

// File: tb/tb_mvm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mvm_ctrl
// Self-checking bench for mvm_ctrl at M = 4. Cycle c is the clock period that
// begins at edge E+c, where E is the edge that samples start=1 in IDLE.
// Expected job timeline (M = 4):
//   LOAD_A 0..15, LOAD_X 16..19, CALC reads 20..35, en_acc 21..36,
//   y_we at 25/29/33/37, done at 37, OUT 38..41, IDLE from 42.
// A small behavioural datapath (memories, MAC, y bank) hangs off the
// controller outputs so full matrix-vector results can be compared against
// a reference sum.
// -----------------------------------------------------------------------------
module tb_mvm_ctrl;

    localparam int M      = 4;
    localparam int T_X    = M * M;          // first LOAD_X cycle
    localparam int T_C    = T_X + M;        // first CALC read
    localparam int T_D    = T_C + M * M;    // DRAIN cycle
    localparam int T_DONE = T_D + 1;        // done pulse
    localparam int T_OUT  = T_DONE + 1;     // first out_valid
    localparam int T_END  = T_OUT + M;      // first IDLE cycle after job
    localparam int NJOBS  = 1000;

    // ---------------------------------------------------------------- clock/reset
    logic clk   = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;

    always #5 clk = ~clk;

    logic       busy;
    logic       wr_en_a;
    logic [3:0] wr_addr_a;
    logic       wr_en_x;
    logic [1:0] wr_addr_x;
    logic [3:0] rd_addr_a;
    logic [1:0] rd_addr_x;
    logic       en_acc;
    logic       clear_acc;
    logic       y_we;
    logic [1:0] y_addr;
    logic       done;
    logic       out_valid;
    logic [1:0] out_row;

    mvm_ctrl #(.MAT_SCALE(M)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .wr_en_a   (wr_en_a),
        .wr_addr_a (wr_addr_a),
        .wr_en_x   (wr_en_x),
        .wr_addr_x (wr_addr_x),
        .rd_addr_a (rd_addr_a),
        .rd_addr_x (rd_addr_x),
        .en_acc    (en_acc),
        .clear_acc (clear_acc),
        .y_we      (y_we),
        .y_addr    (y_addr),
        .done      (done),
        .out_valid (out_valid),
        .out_row   (out_row)
    );

    // ---------------------------------------------------------------- datapath model
    logic signed [7:0]  data_in = '0;
    logic signed [7:0]  mem_a [16];
    logic signed [7:0]  mem_x [4];
    logic signed [7:0]  a_q;
    logic signed [7:0]  x_q;
    logic signed [31:0] prod;
    logic signed [31:0] acc;
    logic signed [31:0] y_bank [4];
    logic signed [31:0] data_out;

    assign prod     = a_q * x_q;
    assign data_out = y_bank[out_row];

    always_ff @(posedge clk) begin
        if (wr_en_a) mem_a[wr_addr_a] <= data_in;
        if (wr_en_x) mem_x[wr_addr_x] <= data_in;
        a_q <= mem_a[rd_addr_a];
        x_q <= mem_x[rd_addr_x];
        if (en_acc) acc <= clear_acc ? prod : acc + prod;
        if (y_we) y_bank[y_addr] <= acc;
    end

    // ---------------------------------------------------------------- expectations
    typedef struct packed {
        logic       busy;
        logic       wr_en_a;
        logic [3:0] wr_addr_a;
        logic       wr_en_x;
        logic [1:0] wr_addr_x;
        logic [3:0] rd_addr_a;
        logic [1:0] rd_addr_x;
        logic       en_acc;
        logic       clear_acc;
        logic       y_we;
        logic [1:0] y_addr;
        logic       done;
        logic       out_valid;
        logic [1:0] out_row;
    } obs_t;

    int checks   = 0;
    int failures = 0;

    // Expected outputs in cycle c of a job, straight from the job timeline.
    function automatic obs_t exp_at(input int c);
        obs_t e;
        e = '0;
        e.busy = (c >= 0) && (c < T_END);
        if (c >= 0 && c < T_X) begin
            e.wr_en_a   = 1'b1;
            e.wr_addr_a = 4'(c);
        end
        if (c >= T_X && c < T_C) begin
            e.wr_en_x   = 1'b1;
            e.wr_addr_x = 2'(c - T_X);
        end
        if (c >= T_C && c < T_D) begin
            e.rd_addr_a = 4'(c - T_C);
            e.rd_addr_x = 2'((c - T_C) % M);
        end
        if (c >= T_C + 1 && c <= T_D) begin
            e.en_acc    = 1'b1;
            e.clear_acc = ((c - T_C - 1) % M) == 0;
        end
        if (c >= T_C + M + 1 && c <= T_DONE && ((c - T_C - M - 1) % M) == 0) begin
            e.y_we   = 1'b1;
            e.y_addr = 2'((c - T_C - M - 1) / M);
        end
        e.done = (c == T_DONE);
        if (c >= T_OUT && c < T_END) begin
            e.out_valid = 1'b1;
            e.out_row   = 2'(c - T_OUT);
        end
        return e;
    endfunction

    function automatic obs_t raw_obs();
        obs_t o;
        o.busy      = busy;
        o.wr_en_a   = wr_en_a;
        o.wr_addr_a = wr_addr_a;
        o.wr_en_x   = wr_en_x;
        o.wr_addr_x = wr_addr_x;
        o.rd_addr_a = rd_addr_a;
        o.rd_addr_x = rd_addr_x;
        o.en_acc    = en_acc;
        o.clear_acc = clear_acc;
        o.y_we      = y_we;
        o.y_addr    = y_addr;
        o.done      = done;
        o.out_valid = out_valid;
        o.out_row   = out_row;
        return o;
    endfunction

    // Observed outputs with each address kept only where the job uses it.
    function automatic obs_t act_obs(input int c, input obs_t e);
        obs_t o;
        o = raw_obs();
        if (!e.wr_en_a) o.wr_addr_a = '0;
        if (!e.wr_en_x) o.wr_addr_x = '0;
        if (!(c >= T_C && c < T_D)) begin
            o.rd_addr_a = '0;
            o.rd_addr_x = '0;
        end
        if (!e.y_we)      o.y_addr  = '0;
        if (!e.out_valid) o.out_row = '0;
        return o;
    endfunction

    // ---------------------------------------------------------------- driver tasks
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Returns #1 into cycle 0 of the new job.
    task automatic pulse_start();
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        obs_t o;
        reset = 1'b0;
        start = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            o = raw_obs();
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL reset_low cyc=%0d got=%h exp=%h", i, o, obs_t'('0));
            end
        end
        start = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            o = raw_obs();
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL reset_released cyc=%0d got=%h exp=%h", i, o, obs_t'('0));
            end
        end
    endtask

    task automatic test_single_job();
        obs_t e;
        obs_t a;
        pulse_start();
        for (int c = 0; c <= T_END; c++) begin
            if (c > 0) next_cycle();
            e = exp_at(c);
            a = act_obs(c, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL single_job c=%0d got=%h exp=%h", c, a, e);
            end
        end
    endtask

    task automatic test_calc_order();
        logic [5:0] exp_q[$];
        logic [5:0] want;
        int         clr_cnt  = 0;
        int         y_row    = 0;
        int         last_wb  = 0;
        for (int j = 0; j < M; j++)
            for (int k = 0; k < M; k++)
                exp_q.push_back({4'(j * M + k), 2'(k)});
        pulse_start();
        for (int c = 0; c <= T_END; c++) begin
            if (c > 0) next_cycle();
            if (c >= T_C && c < T_D) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL calc_pair c=%0d got=%h exp=none", c, {rd_addr_a, rd_addr_x});
                end else begin
                    want = exp_q.pop_front();
                    if ({rd_addr_a, rd_addr_x} !== want) begin
                        failures++;
                        $display("FAIL calc_pair c=%0d got=%h exp=%h", c, {rd_addr_a, rd_addr_x}, want);
                    end
                end
            end
            if (clear_acc === 1'b1) begin
                clr_cnt++;
                checks++;
                if (en_acc !== 1'b1) begin
                    failures++;
                    $display("FAIL clear_with_en c=%0d got=%b exp=1", c, en_acc);
                end
            end
            if (y_we === 1'b1) begin
                checks++;
                if (y_addr !== 2'(y_row)) begin
                    failures++;
                    $display("FAIL y_we_row c=%0d got=%0d exp=%0d", c, y_addr, y_row);
                end
                if (y_row > 0) begin
                    checks++;
                    if (c - last_wb !== M) begin
                        failures++;
                        $display("FAIL y_we_spacing c=%0d got=%0d exp=%0d", c, c - last_wb, M);
                    end
                end
                last_wb = c;
                y_row++;
            end
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL calc_pairs_left got=%0d exp=0", exp_q.size());
        end
        checks++;
        if (clr_cnt !== M) begin
            failures++;
            $display("FAIL clear_count got=%0d exp=%0d", clr_cnt, M);
        end
        checks++;
        if (y_row !== M) begin
            failures++;
            $display("FAIL y_we_count got=%0d exp=%0d", y_row, M);
        end
    endtask

    task automatic test_start_ignored();
        obs_t e;
        obs_t a;
        pulse_start();
        for (int c = 0; c <= T_END; c++) begin
            if (c > 0) next_cycle();
            e = exp_at(c);
            a = act_obs(c, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL start_ignored c=%0d got=%h exp=%h", c, a, e);
            end
            start = (c == 10) || (c == 30);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        obs_t e;
        obs_t a;
        obs_t o;
        pulse_start();
        for (int c = 0; c < 25; c++) begin
            if (c > 0) next_cycle();
            e = exp_at(c);
            a = act_obs(c, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL reset_mid_pre c=%0d got=%h exp=%h", c, a, e);
            end
        end
        next_cycle();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) #1;
            else next_cycle();
            if (i == 2) reset = 1'b1;
            o = raw_obs();
            checks++;
            if (o !== '0) begin
                failures++;
                $display("FAIL reset_mid_zero i=%0d got=%h exp=%h", i, o, obs_t'('0));
            end
        end
        pulse_start();
        for (int c = 0; c <= T_END; c++) begin
            if (c > 0) next_cycle();
            e = exp_at(c);
            a = act_obs(c, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL reset_mid_rerun c=%0d got=%h exp=%h", c, a, e);
            end
        end
    endtask

    // start held high: the second job begins after the single IDLE cycle.
    task automatic test_back_to_back();
        obs_t e;
        obs_t a;
        int   ec;
        int   done_cnt = 0;
        pulse_start();
        start = 1'b1;
        for (int c = 0; c <= 2 * (T_END + 1); c++) begin
            if (c > 0) next_cycle();
            ec = (c <= T_END) ? c : c - (T_END + 1);
            e  = exp_at(ec);
            a  = act_obs(ec, e);
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL back_to_back c=%0d got=%h exp=%h", c, a, e);
            end
            if (done === 1'b1) done_cnt++;
            if (c == 2 * T_END + 1) start = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (done_cnt !== 2) begin
            failures++;
            $display("FAIL back_to_back_jobs got=%0d exp=2", done_cnt);
        end
    endtask

    task automatic test_datapath();
        int a_mat [16];
        int x_vec [4];
        int ref_y [4];
        for (int n = 0; n < NJOBS; n++) begin
            for (int i = 0; i < M * M; i++) a_mat[i] = int'($urandom_range(90)) - 45;
            for (int i = 0; i < M; i++)     x_vec[i] = int'($urandom_range(90)) - 45;
            for (int j = 0; j < M; j++) begin
                ref_y[j] = 0;
                for (int k = 0; k < M; k++) ref_y[j] += a_mat[j * M + k] * x_vec[k];
            end
            pulse_start();
            for (int c = 0; c <= T_END; c++) begin
                if (c > 0) next_cycle();
                if (c < T_X)      data_in = 8'(a_mat[c]);
                else if (c < T_C) data_in = 8'(x_vec[c - T_X]);
                else              data_in = '0;
                if (c >= T_OUT && c < T_END) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_row !== 2'(c - T_OUT)) begin
                        failures++;
                        $display("FAIL dp_out_row job=%0d c=%0d got=%b/%0d exp=1/%0d",
                                 n, c, out_valid, out_row, c - T_OUT);
                    end
                    checks++;
                    if (data_out !== 32'(ref_y[c - T_OUT])) begin
                        failures++;
                        $display("FAIL dp_data job=%0d row=%0d got=%0d exp=%0d",
                                 n, c - T_OUT, data_out, ref_y[c - T_OUT]);
                    end
                end
            end
        end
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        test_reset();
        test_single_job();
        test_calc_order();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        test_datapath();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
